spi_wb_bridge_slave: RTL and testbench

//  SPI mode-0 slave that decodes host command frames and masters a single 32-bit Wishbone

---
 rtl/spi_wb_bridge_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_wb_bridge_slave.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_bridge_slave.sv
// spi_wb_bridge_slave: SPI mode-0 slave that turns each command frame into one 32-bit Wishbone classic cycle
module spi_wb_bridge_slave #(
    parameter logic [7:0] CMD_READ   = 8'hA1,
    parameter logic [7:0] CMD_WRITE  = 8'hA2,
    parameter logic [7:0] RESP_OK    = 8'hA3,
    parameter logic [7:0] RESP_ERR   = 8'hA4,
    parameter int         WB_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_spi_clk,
    input  logic        i_spi_cs_n,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);
    localparam int TW = $clog2(WB_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, WB_READ, WB_WRITE, RESP, IGNORE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      sclk_s, cs_s;
    logic [1:0]      mosi_s;
    logic            rise, fall, cs_fall, cs_rise, in_frame, rx_done;
    logic            start, done, timeout, is_write, own, resp_ok;
    logic [2:0]      bit_cnt, resp_idx;
    logic [1:0]      byte_cnt;
    logic [6:0]      rx_shift;
    logic [7:0]      rx_byte, tx_shift, resp_byte;
    logic [31:0]     adr_shift, dat_shift, rd_data;
    logic [TW-1:0]   tmo_cnt;

    assign rise      = sclk_s[1] & ~sclk_s[2];
    assign fall      = ~sclk_s[1] & sclk_s[2];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign in_frame  = state != IDLE;
    assign rx_done   = rise && in_frame && bit_cnt == 3'd7;
    assign rx_byte   = {rx_shift, mosi_s[1]};
    assign timeout   = tmo_cnt == TW'(WB_TIMEOUT - 1);
    assign done      = o_wb_cyc && own && (i_wb_ack || i_wb_err || timeout);
    assign start     = (state == WB_READ || state == WB_WRITE) && !o_wb_cyc && !cs_rise;
    assign o_spi_miso = tx_shift[7];
    assign resp_byte = resp_idx == 3'd0 ? (resp_ok ? RESP_OK : RESP_ERR) :
                       resp_idx == 3'd1 ? rd_data[7:0] :
                       resp_idx == 3'd2 ? rd_data[15:8] :
                       resp_idx == 3'd3 ? rd_data[23:16] : rd_data[31:24];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_s <= '0;
            cs_s   <= '0;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], i_spi_clk};
            cs_s   <= {cs_s[1:0], i_spi_cs_n};
            mosi_s <= {mosi_s[0], i_spi_mosi};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = cs_fall ? CMD : IDLE;
            CMD:      if (rx_done) state_nxt = (rx_byte == CMD_READ || rx_byte == CMD_WRITE) ? ADDR : IGNORE;
            ADDR:     if (rx_done && byte_cnt == 2'd3) state_nxt = is_write ? WDATA : WB_READ;
            WDATA:    if (rx_done && byte_cnt == 2'd3) state_nxt = WB_WRITE;
            WB_READ:  if (done) state_nxt = RESP;
            WB_WRITE: if (done) state_nxt = IGNORE;
            RESP:     if (rx_done && resp_idx == 3'd5) state_nxt = IGNORE;
            default:  state_nxt = state;
        endcase
        if (cs_rise) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            rx_shift  <= '0;
            is_write  <= 1'b0;
            adr_shift <= '0;
            dat_shift <= '0;
        end else if (cs_rise || !in_frame) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= rx_byte[6:0];
            if (rx_done) begin
                if (state == CMD)   is_write  <= rx_byte == CMD_WRITE;
                if (state == ADDR)  adr_shift <= {adr_shift[23:0], rx_byte};
                if (state == WDATA) dat_shift <= {rx_byte, dat_shift[31:8]};
                if (state == ADDR || state == WDATA) byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    // Next byte is loaded on the falling edge that ends the previous byte; its content is fixed then
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_shift <= '0;
            resp_idx <= '0;
        end else if (cs_rise || !in_frame) begin
            tx_shift <= '0;
            resp_idx <= '0;
        end else if (fall) begin
            if (bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end else if (state == RESP) begin
                tx_shift <= resp_byte;
                resp_idx <= resp_idx + 3'd1;
            end else begin
                tx_shift <= '0;
            end
        end
    end

    // A cycle orphaned by CS rising still runs to completion, but own=0 keeps its result away from the FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_sel <= '0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            own      <= 1'b0;
            resp_ok  <= 1'b0;
            rd_data  <= '0;
            tmo_cnt  <= '0;
        end else if (start) begin
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_we  <= state == WB_WRITE;
            o_wb_sel <= 4'hF;
            o_wb_adr <= adr_shift;
            o_wb_dat <= dat_shift;
            own      <= 1'b1;
            tmo_cnt  <= '0;
        end else if (o_wb_cyc) begin
            if (i_wb_ack || i_wb_err || timeout) begin
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
                o_wb_we  <= 1'b0;
                o_wb_sel <= '0;
                own      <= 1'b0;
                resp_ok  <= i_wb_ack && !i_wb_err;
                rd_data  <= (i_wb_ack && !i_wb_err) ? i_wb_dat : '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
                if (cs_rise) own <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_wb_bridge_slave.sv
// tb_spi_wb_bridge_slave: directed frames with scoreboards for MISO bytes and Wishbone cycles
module tb_spi_wb_bridge_slave;
    localparam int HALF = 80;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } wb_exp_t;

    logic        clk = 0, rst_n = 0, spi_clk = 0, spi_cs_n = 1, spi_mosi = 0, spi_miso;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i = '0;
    logic        wb_we, wb_cyc, wb_stb, wb_ack = 0, wb_err = 0;
    logic [3:0]  wb_sel;

    int          checks = 0, failures = 0;
    wb_exp_t     wb_q[$];
    logic [7:0]  miso_q[$];
    int          ack_lat = 3, wait_cnt = 0, wb_count = 0, cyc_len = 0, last_cyc_len = 0;
    logic        err_mode = 0, cyc_prev = 0;
    logic [31:0] slave_rdata = '0;

    always #5 clk = ~clk;

    spi_wb_bridge_slave dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_spi_clk(spi_clk), .i_spi_cs_n(spi_cs_n),
        .i_spi_mosi(spi_mosi), .o_spi_miso(spi_miso), .o_wb_adr(wb_adr), .o_wb_dat(wb_dat_o),
        .i_wb_dat(wb_dat_i), .o_wb_we(wb_we), .o_wb_sel(wb_sel), .o_wb_cyc(wb_cyc),
        .o_wb_stb(wb_stb), .i_wb_ack(wb_ack), .i_wb_err(wb_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wishbone monitor (pops expected cycles) and slave responder
    always @(negedge clk) begin
        wb_exp_t e;
        if (wb_cyc && !cyc_prev) begin
            wb_count++;
            cyc_len = 0;
            check("wb_expected", 32'(wb_q.size() > 0), 32'd1);
            if (wb_q.size() > 0) begin
                e = wb_q.pop_front();
                check("wb_adr", wb_adr, e.adr);
                check("wb_we", 32'(wb_we), 32'(e.we));
                check("wb_sel", 32'(wb_sel), 32'hF);
                check("wb_stb", 32'(wb_stb), 32'd1);
                if (e.we) check("wb_dat", wb_dat_o, e.dat);
            end
        end
        if (wb_cyc) cyc_len++;
        if (!wb_cyc && cyc_prev) last_cyc_len = cyc_len;
        cyc_prev = wb_cyc;
        if (!wb_cyc) begin
            wb_ack = 0;
            wb_err = 0;
            wait_cnt = 0;
        end else if (wb_stb && !wb_ack && !wb_err) begin
            wait_cnt++;
            if (ack_lat > 0 && wait_cnt >= ack_lat) begin
                if (err_mode) wb_err = 1;
                else begin
                    wb_ack = 1;
                    wb_dat_i = slave_rdata;
                end
            end
        end
    end

    task automatic spi_xfer(input logic [7:0] tx, input string tag);
        logic [7:0] rx, ex;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #HALF;
            rx[i] = spi_miso;
            spi_clk = 1;
            #HALF;
            spi_clk = 0;
        end
        check({tag, "_exp_avail"}, 32'(miso_q.size() > 0), 32'd1);
        ex = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hxx;
        check(tag, 32'(rx), 32'(ex));
    endtask

    task automatic send(input logic [7:0] b[$], input string tag);
        foreach (b[i]) spi_xfer(b[i], $sformatf("%s_miso%0d", tag, i));
    endtask

    task automatic expect_miso(input logic [7:0] b[$]);
        foreach (b[i]) miso_q.push_back(b[i]);
    endtask

    task automatic cs_low();
        spi_cs_n = 0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        spi_cs_n = 1;
        #(4 * HALF);
    endtask

    task automatic wait_cycles(input int target, input string tag);
        int n = 0;
        while (wb_count < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (wb_cyc && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_count"}, 32'(wb_count), 32'(target));
        check({tag, "_cyc_low"}, 32'(wb_cyc), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_cyc", 32'(wb_cyc), 32'd0);
        check("rst_stb", 32'(wb_stb), 32'd0);
        check("rst_sel", 32'(wb_sel), 32'd0);
        check("rst_adr", wb_adr, 32'd0);
        rst_n = 1;
        repeat (10) @(negedge clk);

        // 1: write 0x0000000F to 0
        ack_lat = 3;
        wb_q.push_back('{32'h0, 32'h0000000F, 1'b1});
        expect_miso('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        cs_low();
        send('{8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00}, "t1");
        wait_cycles(1, "t1");
        cs_high();

        // 2: read, ack after 3 clocks
        slave_rdata = 32'h0000000F;
        wb_q.push_back('{32'h0, 32'h0, 1'b0});
        expect_miso('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA3, 8'h0F, 8'h00, 8'h00, 8'h00});
        cs_low();
        send('{8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, "t2");
        cs_high();
        check("t2_count", 32'(wb_count), 32'd2);

        // 3: read with no ack -> timeout; the byte preloaded while pending reads 0x00
        ack_lat = 0;
        wb_q.push_back('{32'h00000010, 32'h0, 1'b0});
        expect_miso('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        cs_low();
        send('{8'hA1, 8'h00, 8'h00, 8'h00, 8'h10}, "t3a");
        wait_cycles(3, "t3");
        check("t3_cyc_len", 32'(last_cyc_len), 32'd255);
        expect_miso('{8'h00, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00});
        send('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, "t3b");
        cs_high();

        // error response: data bytes forced to zero
        ack_lat = 2;
        err_mode = 1;
        slave_rdata = 32'hFFFFFFFF;
        wb_q.push_back('{32'h00000020, 32'h0, 1'b0});
        expect_miso('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00});
        cs_low();
        send('{8'hA1, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, "terr");
        cs_high();
        err_mode = 0;
        check("terr_count", 32'(wb_count), 32'd4);

        // 4: slow ack, host clocks two bytes before the response
        ack_lat = 150;
        slave_rdata = 32'h11223344;
        wb_q.push_back('{32'h00000030, 32'h0, 1'b0});
        expect_miso('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'hA3, 8'h44, 8'h33, 8'h22, 8'h11});
        cs_low();
        send('{8'hA1, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, "t4");
        cs_high();
        check("t4_count", 32'(wb_count), 32'd5);

        // 5: aborted address phase, then a normal write with a trailing extra byte
        ack_lat = 3;
        expect_miso('{8'h00, 8'h00, 8'h00});
        cs_low();
        send('{8'hA2, 8'h12, 8'h34}, "t5a");
        cs_high();
        repeat (300) @(negedge clk);
        check("t5_no_cycle", 32'(wb_count), 32'd5);
        wb_q.push_back('{32'h12345678, 32'hDEADBEEF, 1'b1});
        expect_miso('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        cs_low();
        send('{8'hA2, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h99}, "t5b");
        wait_cycles(6, "t5b");
        cs_high();

        // 6: unknown command, then reset in the middle of a write
        expect_miso('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        cs_low();
        send('{8'h55, 8'hA2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, "t6a");
        cs_high();
        repeat (50) @(negedge clk);
        check("t6_no_cycle", 32'(wb_count), 32'd6);
        expect_miso('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        cs_low();
        send('{8'hA2, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11, 8'h22}, "t6b");
        @(negedge clk);
        rst_n = 0;
        #30;
        check("t6_rst_miso", 32'(spi_miso), 32'd0);
        check("t6_rst_cyc", 32'(wb_cyc), 32'd0);
        check("t6_rst_we", 32'(wb_we), 32'd0);
        check("t6_rst_sel", 32'(wb_sel), 32'd0);
        check("t6_rst_adr", wb_adr, 32'd0);
        check("t6_rst_dat", wb_dat_o, 32'd0);
        @(negedge clk);
        rst_n = 1;
        expect_miso('{8'h00, 8'h00});
        send('{8'h33, 8'h44}, "t6c");
        repeat (300) @(negedge clk);
        check("t6_rst_no_cycle", 32'(wb_count), 32'd6);
        cs_high();

        // recovery: full read after reset
        ack_lat = 1;
        slave_rdata = 32'hCAFEF00D;
        wb_q.push_back('{32'hABCDEF01, 32'h0, 1'b0});
        expect_miso('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA3, 8'h0D, 8'hF0, 8'hFE, 8'hCA});
        cs_low();
        send('{8'hA1, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, "t7");
        cs_high();
        check("t7_count", 32'(wb_count), 32'd7);
        check("wb_q_drained", 32'(wb_q.size()), 32'd0);
        check("miso_q_drained", 32'(miso_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
